piso_tx: RTL and testbench



---
 rtl/piso_tx_if.sv | 31 +++
 rtl/piso_tx.sv | 121 ++++++++++++
 tb/tb_piso_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for the 4-bit PISO transmitter.
// The master side drives bit-rate enable and data; the slave side is the transmitter.
interface piso_tx_if;
  logic       CE;
  logic [3:0] d;
  logic       load;
  logic       ready;
  logic       sout;
  logic       busy;
  logic       done;

  modport master (
    output CE,
    output d,
    output load,
    input  ready,
    input  sout,
    input  busy,
    input  done
  );

  modport slave (
    input  CE,
    input  d,
    input  load,
    output ready,
    output sout,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// 4-bit parallel-in serial-out transmitter.
// Frame: start(0), d[0], d[1], d[2], d[3], stop(1); one bit per clk edge with CE=1.
//
// state | meaning
// IDLE  | line idle at 1, ready for a new word
// START | start bit (0) on the line
// DATA  | shift-register LSB on the line, four bit periods
// STOP  | stop bit (1) on the line; leaving it pulses done
module piso_tx (
  input  logic clk,
  input  logic rst_n,
  piso_tx_if.slave tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] shreg_q, shreg_d;
  logic       sout_q, sout_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // State, datapath and registered outputs; reset forces the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shreg_q <= 4'b0000;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and next output values; everything holds unless CE advances the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sout_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx.load && tx.CE) begin
          state_d = START;
          shreg_d = tx.d;
          cnt_d   = 2'd0;
          sout_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (tx.CE) begin
          state_d = DATA;
          sout_d  = shreg_q[0];
        end
      end

      DATA: begin
        if (tx.CE) begin
          shreg_d = {1'b0, shreg_q[3:1]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            // The bit after this shift is the next LSB, i.e. shreg_q[1].
            sout_d = shreg_q[1];
          end
        end
      end

      STOP: begin
        if (tx.CE) begin
          state_d = IDLE;
          sout_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sout_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx.sout  = sout_q;
  assign tx.ready = ready_q;
  assign tx.busy  = busy_q;
  assign tx.done  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus random traffic,
// compared against a frame-level reference model.
module tb_piso_tx;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  piso_tx_if bus ();

  piso_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is 6 bit periods of {stop, d, start} indexed 0..5.
  bit       m_active;
  int       m_idx;
  bit [3:0] m_word;
  bit       m_done;

  function automatic bit exp_sout();
    logic [5:0] frame;
    frame = {1'b1, m_word, 1'b0};
    if (!m_active) return 1'b1;
    return frame[m_idx];
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sout"},  bus.sout,  exp_sout());
    check({tag, ".ready"}, bus.ready, !m_active);
    check({tag, ".busy"},  bus.busy,  m_active);
    check({tag, ".done"},  bus.done,  m_done);
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
  task automatic tick(input string tag, input bit ce, input bit ld, input bit [3:0] dv);
    bus.CE   = ce;
    bus.load = ld;
    bus.d    = dv;
    @(posedge clk);
    m_done = 1'b0;
    if (m_active) begin
      if (ce) begin
        m_idx++;
        if (m_idx == 6) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (ld && ce) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_word   = dv;
    end
    #1;
    check_outputs(tag);
  endtask

  logic [5:0] cap;
  int         busy_cnt;

  initial begin
    total = 0;
    bad   = 0;
    m_active = 1'b0;
    m_idx    = 0;
    m_word   = 4'b0000;
    m_done   = 1'b0;
    bus.CE   = 1'b0;
    bus.load = 1'b0;
    bus.d    = 4'b0000;
    rst_n    = 1'b0;

    // Reset state
    #12;
    check_outputs("reset");
    rst_n = 1'b1;
    tick("idle0", 1'b1, 1'b0, 4'h0);

    // d=1010, continuous CE: line 0,0,1,0,1,1 then done with ready
    tick("f1010", 1'b1, 1'b1, 4'b1010);
    cap[0] = bus.sout;
    for (int i = 1; i < 6; i++) begin
      tick("f1010", 1'b1, 1'b0, 4'b1010);
      cap[i] = bus.sout;
    end
    check_int("f1010.seq", int'(cap), int'(6'b110100));
    tick("f1010.end", 1'b1, 1'b0, 4'b1010);
    check("f1010.done", bus.done, 1'b1);
    check("f1010.ready", bus.ready, 1'b1);
    tick("f1010.post", 1'b1, 1'b0, 4'b1010);
    check("f1010.done_pulse", bus.done, 1'b0);

    // d=0111, CE 1-of-4: each bit held 4 clocks, busy for 24 clocks
    busy_cnt = 0;
    for (int i = 0; i < 28; i++) begin
      tick("ce4", (i % 4) == 0, i == 0, 4'b0111);
      if (bus.busy === 1'b1) busy_cnt++;
      if ((i % 4) == 0 && i < 24) cap[i / 4] = bus.sout;
    end
    check_int("ce4.busy_cycles", busy_cnt, 24);
    check_int("ce4.seq", int'(cap), int'(6'b101110));

    // d=0001 frame; d changed to 1111 and load pulsed during DATA
    tick("ign", 1'b1, 1'b1, 4'b0001);
    cap[0] = bus.sout;
    for (int i = 1; i < 6; i++) begin
      tick("ign", 1'b1, (i == 2 || i == 3), (i >= 2) ? 4'b1111 : 4'b0001);
      cap[i] = bus.sout;
    end
    check_int("ign.seq", int'(cap), int'(6'b100010));
    tick("ign.end", 1'b1, 1'b0, 4'b1111);
    tick("ign.idle", 1'b1, 1'b0, 4'b1111);

    // Back-to-back with load held: 1100 then 0011, one idle cycle between
    tick("b2b.a", 1'b1, 1'b1, 4'b1100);
    for (int i = 1; i < 6; i++) tick("b2b.a", 1'b1, 1'b1, 4'b0011);
    tick("b2b.gap", 1'b1, 1'b1, 4'b0011);
    check("b2b.gap_sout", bus.sout, 1'b1);
    check("b2b.gap_done", bus.done, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick("b2b.b", 1'b1, 1'b1, 4'b0011);
      cap[i] = bus.sout;
    end
    check_int("b2b.seq", int'(cap), int'(6'b100110));
    tick("b2b.end", 1'b1, 1'b0, 4'b0011);
    tick("b2b.idle", 1'b1, 1'b0, 4'b0011);

    // CE held low for 10 cycles in START, then resume
    tick("hold", 1'b1, 1'b1, 4'b0110);
    for (int i = 0; i < 10; i++) begin
      tick("hold.start", 1'b0, 1'b1, 4'b1001);
      check("hold.sout0", bus.sout, 1'b0);
    end
    for (int i = 0; i < 7; i++) tick("hold.resume", 1'b1, 1'b0, 4'b1001);

    // Asynchronous reset in the middle of DATA, between clock edges
    tick("rst", 1'b1, 1'b1, 4'b0100);
    tick("rst", 1'b1, 1'b0, 4'b0100);
    tick("rst", 1'b1, 1'b0, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    m_idx    = 0;
    m_done   = 1'b0;
    check_outputs("rst.async");
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick("rst.after", 1'b1, 1'b0, 4'b0100);
    tick("rst.accept", 1'b1, 1'b1, 4'b1011);
    for (int i = 0; i < 7; i++) tick("rst.frame", 1'b1, 1'b0, 4'b0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom % 3) != 0, ($urandom % 2) == 0, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
